// File: rtl/divider.sv
// divider: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands are reduced to magnitudes on capture, one quotient bit is formed
// per CALC cycle, and the sign fix-up is folded into the final result write.
// Divide-by-zero and signed overflow resolve in a single cycle.
// Handshake: EX raises is_div with operands valid and holds it until div_done;
// div_done pulses for one cycle with div_out valid; dropping is_div during CALC
// abandons the operation without a done pulse.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [2:0]       funct3,
    input  logic             is_div,
    output logic             div_done,
    output logic [WIDTH-1:0] div_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_out_q;
    logic             div_done_q;
    logic             op_rem_q;
    logic             quo_neg_q;
    logic             rem_neg_q;

    // Request decode: operand magnitudes and the single-cycle special cases.
    logic             is_signed;
    logic             is_rem;
    logic             rs1_neg;
    logic             rs2_neg;
    logic [WIDTH-1:0] rs1_mag;
    logic [WIDTH-1:0] rs2_mag;
    logic             div_by_zero;
    logic             overflow;
    logic [WIDTH-1:0] fast_result;

    // Decode the incoming request from the live operands.
    always_comb begin
        is_signed   = ~funct3[0];
        is_rem      = funct3[1];
        rs1_neg     = is_signed & rs1_data[WIDTH-1];
        rs2_neg     = is_signed & rs2_data[WIDTH-1];
        rs1_mag     = rs1_neg ? (~rs1_data + 1'b1) : rs1_data;
        rs2_mag     = rs2_neg ? (~rs2_data + 1'b1) : rs2_data;
        div_by_zero = (rs2_data == '0);
        overflow    = is_signed && (rs1_data == MOST_NEG) && (rs2_data == '1);
        if (div_by_zero) begin
            fast_result = is_rem ? rs1_data : '1;
        end else begin
            fast_result = is_rem ? '0 : rs1_data;
        end
    end

    // One restoring step; the extra top bit of trial exposes the borrow.
    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] result_d;

    // Form the next remainder/quotient and the sign-corrected final result.
    always_comb begin
        shifted = {rem_q[WIDTH-2:0], dividend_q[WIDTH-1]};
        trial   = {1'b0, shifted} - {1'b0, divisor_q};
        rem_d   = trial[WIDTH] ? shifted : trial[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        if (op_rem_q) begin
            result_d = rem_neg_q ? (~rem_d + 1'b1) : rem_d;
        end else begin
            result_d = quo_neg_q ? (~quo_d + 1'b1) : quo_d;
        end
    end

    // Control FSM and datapath registers; div_out only changes when entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_out_q  <= '0;
            div_done_q <= 1'b0;
            op_rem_q   <= 1'b0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
        end else begin
            div_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (is_div) begin
                        op_rem_q   <= is_rem;
                        dividend_q <= rs1_mag;
                        divisor_q  <= rs2_mag;
                        rem_q      <= '0;
                        quo_q      <= '0;
                        count_q    <= '0;
                        quo_neg_q  <= is_signed & (rs1_data[WIDTH-1] ^ rs2_data[WIDTH-1])
                                      & ~div_by_zero;
                        rem_neg_q  <= rs1_neg;
                        if (div_by_zero || overflow) begin
                            state_q    <= DONE;
                            div_out_q  <= fast_result;
                            div_done_q <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!is_div) begin
                        state_q <= IDLE;
                    end else begin
                        dividend_q <= {dividend_q[WIDTH-2:0], 1'b0};
                        rem_q      <= rem_d;
                        quo_q      <= quo_d;
                        count_q    <= count_q + 1'b1;
                        if (count_q == LAST_STEP) begin
                            state_q    <= DONE;
                            div_out_q  <= result_d;
                            div_done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign div_done = div_done_q;
    assign div_out  = div_out_q;

endmodule

// File: tb/tb_divider.sv
// tb_divider: directed and randomised checks of the RV32M divider.
module tb_divider;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    logic        clk;
    logic        rst;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [2:0]  funct3;
    logic        is_div;
    logic        div_done;
    logic [31:0] div_out;

    int checks;
    int failures;

    divider #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .funct3   (funct3),
        .is_div   (is_div),
        .div_done (div_done),
        .div_out  (div_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model built from plain integer arithmetic.
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one request (called #1 after a posedge with the DUT idle), wait for
    // done, check latency/result, then check the pulse is single-cycle.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        bit seen;
        funct3   = f3;
        rs1_data = a;
        rs2_data = b;
        is_div   = 1'b1;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (div_done) seen = 1;
            if (lat == 1) begin
                rs1_data = $urandom;
                rs2_data = $urandom;
                funct3   = 3'($urandom_range(0, 7));
            end
        end
        is_div = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_value"}, div_out, exp);
        @(posedge clk);
        #1;
        check({tag, "_single_pulse"}, 32'(div_done), 32'd0);
    endtask

    initial begin
        int lat;
        int done_cnt;
        bit seen;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        is_div   = 1'b0;
        funct3   = 3'b000;
        rs1_data = '0;
        rs2_data = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_done", 32'(div_done), 32'd0);
        check("reset_out", div_out, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Normal path
        do_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 33);
        do_op("remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2, 33);
        do_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        do_op("rem_m7_2", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        do_op("rem_7_m2", F_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        do_op("divu_max_1", F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

        // Abort: drop is_div in cycle 10; no done, output holds.
        funct3   = F_DIVU;
        rs1_data = 32'd1000;
        rs2_data = 32'd3;
        is_div   = 1'b1;
        done_cnt = 0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (div_done) done_cnt++;
            if (i == 10) is_div = 1'b0;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_out_held", div_out, 32'hFFFF_FFFF);
        do_op("divu_9_3_after_abort", F_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // Divide by zero and signed overflow fast path
        do_op("div_5_0", F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        do_op("divu_5_0", F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        do_op("rem_5_0", F_REM, 32'd5, 32'd0, 32'd5, 1);
        do_op("remu_min_0", F_REMU, 32'h8000_0000, 32'd0, 32'h8000_0000, 1);
        do_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        do_op("divu_ovf_ops", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

        // Back-to-back: is_div held across DONE with new operands.
        funct3   = F_DIVU;
        rs1_data = 32'd100;
        rs2_data = 32'd7;
        is_div   = 1'b1;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (div_done) seen = 1;
        end
        check("b2b_first_latency", 32'(lat), 32'd33);
        check("b2b_first_value", div_out, 32'd14);
        funct3   = F_REM;
        rs1_data = 32'd17;
        rs2_data = 32'd5;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 45) begin
            @(posedge clk);
            #1;
            lat++;
            if (div_done) seen = 1;
        end
        is_div = 1'b0;
        check("b2b_second_latency", 32'(lat), 32'd34);
        check("b2b_second_value", div_out, 32'd2);
        @(posedge clk);
        #1;
        check("b2b_single_pulse", 32'(div_done), 32'd0);

        // Reset in cycle 20 of a divide
        funct3   = F_DIVU;
        rs1_data = 32'd1000;
        rs2_data = 32'd3;
        is_div   = 1'b1;
        done_cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (div_done) done_cnt++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        is_div = 1'b0;
        check("midreset_done", 32'(div_done), 32'd0);
        check("midreset_out", div_out, 32'd0);
        repeat (40) begin
            @(posedge clk);
            #1;
            if (div_done) done_cnt++;
        end
        check("midreset_no_done", 32'(done_cnt), 32'd0);
        do_op("remu_after_reset", F_REMU, 32'd100, 32'd7, 32'd2, 33);

        // Randomised operations against the reference model
        for (int n = 0; n < 12; n++) begin
            rf3 = 3'b100 | 3'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'($urandom_range(1, 20));
                1:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                2:       rb = 32'd0;
                default: rb = $urandom;
            endcase
            if (n == 11) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            do_op($sformatf("rand%0d", n), rf3, ra, rb, ref_div(rf3, ra, rb),
                  ref_lat(rf3, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
